// File: rtl/demux1t8_32_reg.sv
// Registered 1-to-8 write demultiplexer: steers byte-masked writes into eight
// 32-bit holding registers with per-channel update pulse, fresh and overrun flags.
module demux1t8_32_reg #(
    parameter logic [31:0] INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  s,
    input  logic [3:0]  be,
    input  logic [31:0] i,
    input  logic [7:0]  ack,
    output logic [31:0] O0,
    output logic [31:0] O1,
    output logic [31:0] O2,
    output logic [31:0] O3,
    output logic [31:0] O4,
    output logic [31:0] O5,
    output logic [31:0] O6,
    output logic [31:0] O7,
    output logic [7:0]  upd,
    output logic [7:0]  fresh,
    output logic [7:0]  ovf,
    output logic [3:0]  wcnt
);

    localparam int unsigned NCH   = 8;
    localparam int unsigned NBYTE = 4;

    logic [31:0] hold [NCH];
    logic [7:0]  wsel_c;
    logic [7:0]  fresh_nxt_c;
    logic [7:0]  ovf_nxt_c;

    // One-hot decode of the accepted write; ack only clears flags of channels not written.
    always_comb begin
        wsel_c      = 8'h00;
        fresh_nxt_c = fresh;
        ovf_nxt_c   = ovf;
        if (we) begin
            wsel_c = 8'(8'h01 << s);
        end
        fresh_nxt_c = wsel_c | (fresh & ~ack);
        ovf_nxt_c   = (wsel_c & fresh & ~ack) | (~wsel_c & ovf & ~ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                hold[k] <= INIT;
            end
            upd   <= 8'h00;
            fresh <= 8'h00;
            ovf   <= 8'h00;
            wcnt  <= 4'h0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                for (int b = 0; b < NBYTE; b++) begin
                    if (wsel_c[k] && be[b]) begin
                        hold[k][8*b +: 8] <= i[8*b +: 8];
                    end
                end
            end
            upd   <= wsel_c;
            fresh <= fresh_nxt_c;
            ovf   <= ovf_nxt_c;
            if (we && (wcnt != 4'hF)) begin
                wcnt <= wcnt + 4'd1;
            end
        end
    end

    assign O0 = hold[0];
    assign O1 = hold[1];
    assign O2 = hold[2];
    assign O3 = hold[3];
    assign O4 = hold[4];
    assign O5 = hold[5];
    assign O6 = hold[6];
    assign O7 = hold[7];

endmodule

// File: tb/tb_demux1t8_32_reg.sv
// Randomized self-checking bench for demux1t8_32_reg against a per-channel
// behavioural model of the write/ack rules.
module tb_demux1t8_32_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [2:0]  s   = 3'h0;
    logic [3:0]  be  = 4'h0;
    logic [31:0] i   = 32'h0;
    logic [7:0]  ack = 8'h00;
    logic [31:0] dut_o [8];
    logic [7:0]  upd, fresh, ovf;
    logic [3:0]  wcnt;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] m_o [8];
    logic [7:0]  m_upd, m_fresh, m_ovf;
    int          m_writes;

    demux1t8_32_reg #(.INIT(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .we(we), .s(s), .be(be), .i(i), .ack(ack),
        .O0(dut_o[0]), .O1(dut_o[1]), .O2(dut_o[2]), .O3(dut_o[3]),
        .O4(dut_o[4]), .O5(dut_o[5]), .O6(dut_o[6]), .O7(dut_o[7]),
        .upd(upd), .fresh(fresh), .ovf(ovf), .wcnt(wcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_o[k] = 32'h0;
        m_upd = 8'h00; m_fresh = 8'h00; m_ovf = 8'h00; m_writes = 0;
    endtask

    // Apply one edge worth of the rules to the model, channel by channel.
    task automatic model_edge(input logic w, input logic [2:0] sel, input logic [3:0] bytes,
                              input logic [31:0] d, input logic [7:0] a);
        m_upd = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (w && (int'(sel) == k)) begin
                for (int b = 0; b < 4; b++)
                    if (bytes[b]) m_o[k][8*b +: 8] = d[8*b +: 8];
                m_upd[k]   = 1'b1;
                m_ovf[k]   = m_fresh[k] && !a[k];
                m_fresh[k] = 1'b1;
            end else if (a[k]) begin
                m_fresh[k] = 1'b0;
                m_ovf[k]   = 1'b0;
            end
        end
        if (w) m_writes++;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 8; k++) chk($sformatf("%s.O%0d", tag, k), dut_o[k], m_o[k]);
        chk({tag, ".upd"},   32'(upd),   32'(m_upd));
        chk({tag, ".fresh"}, 32'(fresh), 32'(m_fresh));
        chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        chk({tag, ".wcnt"},  32'(wcnt),  32'((m_writes > 15) ? 15 : m_writes));
    endtask

    task automatic drive(input string tag, input logic w, input logic [2:0] sel,
                         input logic [3:0] bytes, input logic [31:0] d, input logic [7:0] a);
        @(negedge clk);
        we = w; s = sel; be = bytes; i = d; ack = a;
        @(posedge clk);
        model_edge(w, sel, bytes, d, a);
        #1 check_all(tag);
    endtask

    initial begin
        model_reset();
        #2 check_all("reset");
        @(negedge clk) rst = 1'b0;

        for (int k = 0; k < 8; k++)
            drive("fanout", 1'b1, 3'(k), 4'hF, 32'hA0A0_0000 + 32'(k), 8'h00);
        chk("fanout.fresh", 32'(fresh), 32'h0000_00FF);
        chk("fanout.wcnt",  32'(wcnt),  32'h8);
        chk("fanout.O7",    dut_o[7],   32'hA0A0_0007);

        drive("merge_pre", 1'b1, 3'd3, 4'hF, 32'h1122_3344, 8'hFF);
        drive("merge", 1'b1, 3'd3, 4'b0101, 32'hAABB_CCDD, 8'h00);
        chk("merge.O3", dut_o[3], 32'h11BB_33DD);
        drive("be0", 1'b1, 3'd3, 4'h0, 32'hFFFF_FFFF, 8'h00);
        chk("be0.O3",  dut_o[3], 32'h11BB_33DD);
        chk("be0.upd", 32'(upd), 32'h08);

        drive("ovr_clr", 1'b0, 3'd0, 4'h0, 32'h0, 8'hFF);
        drive("ovr1", 1'b1, 3'd5, 4'hF, 32'h5555_0001, 8'h00);
        drive("ovr2", 1'b1, 3'd5, 4'hF, 32'h5555_0002, 8'h00);
        chk("ovr.ovf5", 32'(ovf[5]), 32'h1);
        drive("ovr_ack", 1'b0, 3'd0, 4'h0, 32'h0, 8'h20);
        chk("ovr_ack.fresh5", 32'(fresh[5]), 32'h0);
        chk("ovr_ack.ovf5",   32'(ovf[5]),   32'h0);

        drive("wa_pre2", 1'b1, 3'd2, 4'hF, 32'h2222_2222, 8'h00);
        drive("wa_pre6", 1'b1, 3'd6, 4'hF, 32'h6666_6666, 8'h00);
        drive("wa", 1'b1, 3'd2, 4'hF, 32'h2222_0000, 8'h44);
        chk("wa.fresh2", 32'(fresh[2]), 32'h1);
        chk("wa.ovf2",   32'(ovf[2]),   32'h0);
        chk("wa.fresh6", 32'(fresh[6]), 32'h0);

        for (int n = 0; n < 150; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            drive("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom), 4'($urandom),
                  $urandom, a);
        end

        // Asynchronous reset mid-cycle, then a write held off by reset.
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        we = 1'b1; s = 3'd1; be = 4'hF; i = 32'hDEAD_BEEF; ack = 8'h00;
        @(posedge clk);
        #1 check_all("rst_write");
        @(negedge clk);
        rst = 1'b0; we = 1'b0;

        for (int n = 0; n < 20; n++)
            drive("sat", 1'b1, 3'($urandom), 4'($urandom), $urandom, 8'h00);
        chk("sat.wcnt", 32'(wcnt), 32'hF);
        drive("sat_hold", 1'b1, 3'd0, 4'hF, 32'h0BAD_F00D, 8'hFF);
        chk("sat_hold.wcnt", 32'(wcnt), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux1t8_32_reg.md
# demux1t8_32_reg

Registered 1-to-8 write demultiplexer for the 32-bit datapath, the write-side counterpart of the 8:1 read selector. A single write port carries data, a 3-bit channel select and byte enables. The block steers each write into one of eight 32-bit holding registers, each driving a downstream consumer such as an I/O register or debug display channel. Every channel has an update pulse, a sticky "fresh" flag that the consumer acknowledges, and an overrun flag for writes that land before the previous value was consumed.

## Interface
Parameters:
- INIT, 32'h0000_0000, reset value loaded into all eight holding registers

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- we  input  1  write strobe; one write per cycle when high
- s  input  3  channel select, 3'h0..3'h7
- be  input  4  byte enables; be[k] covers i[8k+7:8k]
- i  input  32  write data
- ack  input  8  per-channel consume acknowledge; ack[k] clears fresh[k] and ovf[k]
- O0..O7  output  32 each  holding registers, each a register output with no combinational path from inputs
- upd  output  8  one-cycle pulse; upd[k] high the cycle after a write to channel k
- fresh  output  8  sticky; channel k written and not yet acknowledged
- ovf  output  8  sticky; channel k written while fresh[k] was already set and not acked that cycle
- wcnt  output  4  saturating count of accepted writes since reset, all channels

## Operation
- Write accept: on a clk edge with we=1, channel k=s is updated. For each byte b, O_k[8b+7:8b] takes i[8b+7:8b] if be[b]=1 and otherwise holds. Other channels hold.
- A write with be=4'b0000 is still a write. The data is unchanged, but upd, fresh, ovf and wcnt all update as for any other write.
- upd is a registered decode: upd[k] equals 1 exactly when a write to k was accepted on the previous edge. At most one bit of upd is high.
- fresh[k], next state:
  - 1 if a write to k is accepted this edge.
  - Otherwise 0 if ack[k]=1.
  - Otherwise hold.
- ovf[k], next state:
  - 1 if a write to k is accepted this edge, fresh[k]=1 and ack[k]=0.
  - Otherwise 0 if ack[k]=1.
  - Otherwise hold.
- Write and ack to the same channel on the same edge: the ack consumes the old value, the new write sets fresh[k]=1 and ovf[k]=0.
- ack for channel j while a different channel k is written: the two are independent. fresh[j] and ovf[j] clear, channel k updates normally.
- ack to a channel with fresh=0: no effect, no error.
- wcnt increments by 1 per accepted write and saturates at 4'hF with no wrap. Only rst clears it.
- s is always in range (3 bits), so there is no invalid-select case. Inputs are sampled only when we=1.

## Timing
- Reset values: O0..O7=INIT, upd=8'h00, fresh=8'h00, ovf=8'h00, wcnt=4'h0. All take effect immediately on rst assertion, without waiting for a clock edge.
- Reset mid-operation: a write coincident with rst asserted is discarded, and outputs remain at reset values while rst=1. The first write is accepted on the first rising edge with rst=0.
- Latency: a write on edge N makes O_k valid and fresh[k]=1 after edge N. upd[k] is high for the cycle between edges N and N+1.
- Throughput: one write per cycle, back-to-back, to the same or different channels. With consecutive writes to one channel, upd[k] stays high for consecutive cycles.
- ack acts on the edge at which it is sampled. fresh and ovf show the cleared value after that edge.

## Test plan
- Reset: assert rst asynchronously mid-cycle with INIT=32'h0 after prior writes. All O=0, upd=0, fresh=0, ovf=0 and wcnt=0 immediately, before the next edge.
- Full-word fan-out: write i=32'hA0A0_0000+k to s=k with be=4'hF for k=0..7 on consecutive cycles. Each O_k must equal 32'hA0A0_000k. upd must walk 8'h01, 8'h02 … 8'h80 one cycle behind the writes. fresh=8'hFF, wcnt=4'h8.
- Byte merge: with O3=32'h1122_3344, write s=3, be=4'b0101, i=32'hAABB_CCDD. O3 must become 32'h11BB_33DD. A following write with be=0 leaves O3 unchanged but pulses upd[3].
- Overrun: write ch5 twice with no ack, so ovf[5]=1. Then ack[5]=1 alone, giving fresh[5]=0 and ovf[5]=0.
- Simultaneous write and ack on ch2 (fresh[2]=1 beforehand): result fresh[2]=1 and ovf[2]=0. In the same cycle, ack[6] with fresh[6]=1 and no write to ch6: fresh[6]=0.
- Saturation: 20 consecutive writes gives wcnt=4'hF that holds at 4'hF, and O and the flags remain correct.
